// File: rtl/parity_xor_pkg.sv
// Shared constants and helpers for the parity_xor_frame block.
// The optional check-word compare is enabled by defining PARITY_XOR_CHECK_EN.
package parity_xor_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefLenW      = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/parity_xor_ch_acc.sv
// One channel's running XOR, frame length and saturation flag.
// Presents the post-word values so the top can capture them on eof.
module parity_xor_ch_acc
  import parity_xor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned LEN_W      = DefLenW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  sof,
  input  logic                  eof,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] par_nxt,
  output logic [LEN_W-1:0]      len_nxt,
  output logic                  sat_nxt
);

  localparam logic [LEN_W-1:0] LenMax = '1;

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  sat_q, sat_d;
  logic                  ovf;

  always_comb begin
    // Overflow only when an increment would be clamped; sof restarts the count.
    ovf     = !sof && (len_q == LenMax);
    par_nxt = (sof ? '0 : acc_q) ^ data;
    if (sof) begin
      len_nxt = LEN_W'(1);
    end else if (ovf) begin
      len_nxt = LenMax;
    end else begin
      len_nxt = len_q + 1'b1;
    end
    sat_nxt = !sof && (sat_q || ovf);
  end

  always_comb begin
    acc_d = acc_q;
    len_d = len_q;
    sat_d = sat_q;
    if (wr_en) begin
      if (eof) begin
        acc_d = '0;
        len_d = '0;
        sat_d = 1'b0;
      end else begin
        acc_d = par_nxt;
        len_d = len_nxt;
        sat_d = sat_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      len_q <= len_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: rtl/parity_xor_frame.sv
// Multi-channel frame XOR parity accumulator with valid/ready in and out.
// Define PARITY_XOR_CHECK_EN to add m_err (eof word treated as expected parity).
module parity_xor_frame
  import parity_xor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned LEN_W      = DefLenW,
  localparam int unsigned CH_W      = (clog2(CH_NUM) < 1) ? 1 : clog2(CH_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [CH_W-1:0]       s_ch,
  input  logic                  s_sof,
  input  logic                  s_eof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CH_W-1:0]       m_ch,
  output logic [LEN_W-1:0]      m_len,
  output logic                  m_len_sat,
`ifdef PARITY_XOR_CHECK_EN
  output logic                  m_err,
`endif
  output logic                  err_ch
);

  logic                  accept;
  logic                  ch_ok;
  logic [DATA_WIDTH-1:0] par_arr [CH_NUM];
  logic [LEN_W-1:0]      len_arr [CH_NUM];
  logic                  sat_arr [CH_NUM];
  logic [DATA_WIDTH-1:0] sel_par;
  logic [LEN_W-1:0]      sel_len;
  logic                  sel_sat;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [CH_W-1:0]       m_ch_q;
  logic [LEN_W-1:0]      m_len_q;
  logic                  m_len_sat_q;
  logic                  err_ch_q;

  // A held result stalls every channel, not just the one that produced it.
  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign ch_ok   = 32'(s_ch) < CH_NUM;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    parity_xor_ch_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEN_W      (LEN_W)
    ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept && ch_ok && (s_ch == CH_W'(i))),
      .sof     (s_sof),
      .eof     (s_eof),
      .data    (s_data),
      .par_nxt (par_arr[i]),
      .len_nxt (len_arr[i]),
      .sat_nxt (sat_arr[i])
    );
  end

  always_comb begin
    sel_par = '0;
    sel_len = '0;
    sel_sat = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (s_ch == CH_W'(i)) begin
        sel_par = par_arr[i];
        sel_len = len_arr[i];
        sel_sat = sat_arr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ch_q      <= '0;
      m_len_q     <= '0;
      m_len_sat_q <= 1'b0;
      err_ch_q    <= 1'b0;
    end else begin
      err_ch_q <= accept && !ch_ok;
      if (accept && ch_ok && s_eof) begin
        m_valid_q   <= 1'b1;
        m_data_q    <= sel_par;
        m_ch_q      <= s_ch;
        m_len_q     <= sel_len;
        m_len_sat_q <= sel_sat;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

`ifdef PARITY_XOR_CHECK_EN
  logic m_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err_q <= 1'b0;
    end else if (accept && ch_ok && s_eof) begin
      m_err_q <= (sel_par != '0);
    end
  end

  assign m_err = m_err_q;
`endif

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_ch      = m_ch_q;
  assign m_len     = m_len_q;
  assign m_len_sat = m_len_sat_q;
  assign err_ch    = err_ch_q;

endmodule

// File: tb/tb_parity_xor_frame.sv
// Scoreboard bench for parity_xor_frame (CH_NUM=5 so id 5 is out of range, LEN_W=4).
// Covers the m_err path too when PARITY_XOR_CHECK_EN is defined.
module tb_parity_xor_frame;

  localparam int unsigned DW   = 32;
  localparam int unsigned CHN  = 5;
  localparam int unsigned LW   = 4;
  localparam int unsigned CW   = 3;
  localparam int          LMAX = 15;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ch;
    logic [LW-1:0] len;
    logic          sat;
    logic          err;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_sof, s_eof;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_ch;
  logic          m_valid, m_ready, m_len_sat, err_ch;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ch;
  logic [LW-1:0] m_len;
`ifdef PARITY_XOR_CHECK_EN
  logic          m_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  res_t          exp_q[$];
  logic [DW-1:0] acc_m [CHN];
  int            len_m [CHN];
  bit            sat_m [CHN];

  parity_xor_frame #(
    .DATA_WIDTH (DW),
    .CH_NUM     (CHN),
    .LEN_W      (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_ch      (s_ch),
    .s_sof     (s_sof),
    .s_eof     (s_eof),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_ch      (m_ch),
    .m_len     (m_len),
    .m_len_sat (m_len_sat),
`ifdef PARITY_XOR_CHECK_EN
    .m_err     (m_err),
`endif
    .err_ch    (err_ch)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CHN; i++) begin
      acc_m[i] = '0;
      len_m[i] = 0;
      sat_m[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_accept(input int ch, input logic [DW-1:0] d, input bit sof, input bit eof);
    logic [DW-1:0] x;
    int            nl;
    bit            ns;
    res_t          r;
    if (ch >= CHN) return;
    x = (sof ? '0 : acc_m[ch]) ^ d;
    if (sof) begin
      nl = 1;
      ns = 1'b0;
    end else if (len_m[ch] == LMAX) begin
      nl = LMAX;
      ns = 1'b1;
    end else begin
      nl = len_m[ch] + 1;
      ns = sat_m[ch];
    end
    if (eof) begin
      r.data = x;
      r.ch   = CW'(ch);
      r.len  = LW'(nl);
      r.sat  = ns;
      r.err  = (x != '0);
      exp_q.push_back(r);
      acc_m[ch] = '0;
      len_m[ch] = 0;
      sat_m[ch] = 1'b0;
    end else begin
      acc_m[ch] = x;
      len_m[ch] = nl;
      sat_m[ch] = ns;
    end
  endtask

  task automatic send(input int ch, input logic [DW-1:0] d, input bit sof, input bit eof);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_ch    = CW'(ch);
    s_data  = d;
    s_sof   = sof;
    s_eof   = eof;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      check_eq("s_ready_timeout", 64'(s_ready), 64'd1);
    end else begin
      @(posedge clk);
      model_accept(ch, d, sof, eof);
    end
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 64'(m_valid), 64'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check_eq("m_data", 64'(m_data), 64'(e.data));
        check_eq("m_ch", 64'(m_ch), 64'(e.ch));
        check_eq("m_len", 64'(m_len), 64'(e.len));
        check_eq("m_len_sat", 64'(m_len_sat), 64'(e.sat));
`ifdef PARITY_XOR_CHECK_EN
        check_eq("m_err", 64'(m_err), 64'(e.err));
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    s_data  = '0;
    s_ch    = '0;
    m_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_m_data", 64'(m_data), 64'd0);
    check_eq("rst_m_len", 64'(m_len), 64'd0);
    check_eq("rst_err_ch", 64'(err_ch), 64'd0);
    check_eq("rst_s_ready", 64'(s_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three-word frame on ch1, result one cycle after eof.
    send(1, 32'h0000_000F, 1'b1, 1'b0);
    send(1, 32'h0000_00F0, 1'b0, 1'b0);
    send(1, 32'h0000_0F00, 1'b0, 1'b1);
    check_eq("latency_m_valid", 64'(m_valid), 64'd1);
    check_eq("t1_m_data", 64'(m_data), 64'h0000_0FFF);
    repeat (2) @(posedge clk);
    #1;

    // Interleaved ch0/ch2, back-to-back results.
    send(0, 32'hAAAA_AAAA, 1'b1, 1'b0);
    send(2, 32'h1234_5678, 1'b1, 1'b0);
    send(0, 32'h5555_5555, 1'b0, 1'b1);
    send(2, 32'h1234_5678, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Output stall holds the result and blocks input.
    m_ready = 1'b0;
    send(4, 32'h0000_00AB, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_m_valid", 64'(m_valid), 64'd1);
      check_eq("stall_m_data", 64'(m_data), 64'h0000_00AB);
      check_eq("stall_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    #1;
    check_eq("unstall_s_ready", 64'(s_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Out-of-range channel: err_ch pulse, no result, ch0 partial untouched.
    send(0, 32'h0000_0011, 1'b1, 1'b0);
    send(5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check_eq("err_ch_pulse", 64'(err_ch), 64'd1);
    check_eq("err_ch_no_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    check_eq("err_ch_one_cycle", 64'(err_ch), 64'd0);
    send(0, 32'h0000_0022, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame on ch3.
    send(3, 32'h0000_0001, 1'b1, 1'b0);
    send(3, 32'h0000_0002, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_m_valid", 64'(m_valid), 64'd0);
    check_eq("midrst_m_data", 64'(m_data), 64'd0);
    check_eq("midrst_m_len", 64'(m_len), 64'd0);
    check_eq("midrst_m_ch", 64'(m_ch), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3, 32'h0000_0001, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // 20-word frame saturates the 4-bit length counter.
    for (int i = 0; i < 20; i++) begin
      send(4, DW'(i * 7 + 1), i == 0, i == 19);
    end
    repeat (2) @(posedge clk);
    #1;

`ifdef PARITY_XOR_CHECK_EN
    send(1, 32'h3, 1'b1, 1'b0);
    send(1, 32'h5, 1'b0, 1'b0);
    send(1, 32'h6, 1'b0, 1'b1);
    send(2, 32'h3, 1'b1, 1'b0);
    send(2, 32'h5, 1'b0, 1'b0);
    send(2, 32'h7, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
